instr_issue_unit: RTL
=====================

Name: instr_issue_unit

Overview:
- Producer side of the processor's 32-bit instruction interface; drives the processor's instruction input every clock.
- Buffers instructions from an upstream source (program ROM or testbench loader) in a small FIFO.
- Issues one instruction per cycle. Inserts NOP bubbles (32'h0) whenever the head instruction would read a register still in flight in the processor's 5-stage pipeline.
- Provides software-visible issue and bubble counters.

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- HAZARD_DIST, 3: number of most recently issued instructions whose rd blocks a dependent read.
- CNT_W, 32: width of the issued and bubble counters.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0, deasserted synchronously by board logic).
- in_instr  in  32  upstream instruction: [31:28] opcode, [27:24] rd, [23:20] rs1, [19:16] rs2.
- in_valid  in  1  in_instr valid this cycle.
- in_ready  out  1  FIFO can accept; a transfer occurs when in_valid && in_ready at a rising edge.
- flush  in  1  discard all buffered, not-yet-issued instructions.
- instruction  out  32  registered instruction to the processor.
- out_bubble  out  1  high when the current instruction is an inserted NOP.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- issued_cnt  out  CNT_W  real instructions issued; saturates at all-ones.
- bubble_cnt  out  CNT_W  bubbles issued; saturates at all-ones.

Behaviour:
- Reset (reset==0, async):
  - instruction=0, out_bubble=1, fifo_count=0, both counters=0.
  - FIFO pointers=0; all history valid bits=0.
  - in_ready=0 while reset is asserted.
- Register usage by opcode:
  - 1 (ADD) and 2 (SUB) read rs1 and rs2.
  - 3 (LOAD) reads rs1 only.
  - All other opcodes read nothing.
  - Every issued instruction writes rd. r0 is never tracked as a hazard, because bubbles write r0.
- History:
  - A shift register of HAZARD_DIST entries {valid, rd}.
  - Each rising edge shifts in the instruction issued at that edge: valid = (rd != 0) and the slot is not a bubble.
- Hazard: the head reads register r, r != 0, and any valid history entry has rd == r. The check uses history contents before this edge's shift.
- Issue decision per rising edge:
  - FIFO non-empty, no hazard, no flush: instruction <= head, pop, out_bubble <= 0, issued_cnt += 1.
  - Otherwise: instruction <= 32'h0, out_bubble <= 1, bubble_cnt += 1.
- Latency: an instruction pushed at edge N can appear on instruction at edge N+1 at the earliest. A dependent instruction issues no earlier than HAZARD_DIST+1 cycles after its producer, i.e. with HAZARD_DIST bubbles between them.
- FIFO:
  - in_ready = !full && !flush && reset.
  - Push and pop in the same edge leave the count unchanged.
  - Pointers wrap modulo DEPTH.
  - Push while full cannot occur, because ready is low.
- Flush:
  - Empties the FIFO (count=0) at the edge; the slot issued at that edge is a bubble.
  - A push presented in the same cycle is dropped.
  - History is NOT cleared, because those instructions are already in the processor.
- Counters hold at all-ones once saturated; no wrap.
- Reset mid-operation clears everything immediately, independent of the clock.

Decomposition:
- Shared package issue_pkg:
  - Opcode constants OP_ADD=4'h1, OP_SUB=4'h2, OP_LOAD=4'h3.
  - NOP_INSTR=32'h0.
  - Field bit-position constants.
  - Functions reads_rs1(opcode) and reads_rs2(opcode).
- One sub-module, issue_fifo: a parameterised synchronous FIFO with push/pop/flush, count, full and empty.
- The hazard scoreboard and issue logic stay in the top module.

Test Plan:
- Reset, then release with in_valid=0 -> instruction=0, out_bubble=1, fifo_count=0, bubble_cnt increments by 1 per cycle, issued_cnt=0.
- Push 0x11230000 then 0x24560000 on consecutive cycles -> they appear on consecutive cycles one edge after each push; issued_cnt=2, no extra bubbles.
- Push 0x11230000 then 0x34100000 (LOAD r4 from r1) -> exactly 3 bubbles between them; out_bubble high for those 3 cycles; bubble_cnt rises by 3.
- Push 0x10120000 (rd=r0) then 0x13000000 (reads r0) -> no bubble inserted; back-to-back issue.
- Stall the head behind a hazard while pushing continuously -> in_ready drops when fifo_count=4; the 5th word is held until a pop; order is preserved across pointer wrap.
- Mid-operation tests:
  - Flush with 3 buffered entries -> fifo_count=0 next edge, only bubbles issue, and a subsequent dependent instruction still honours history.
  - Assert reset mid-stream -> all outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/issue_pkg.sv
// Shared definitions for the instruction issue unit: opcodes, field positions
// and register-usage decode.
package issue_pkg;

   localparam logic [3:0]  OP_ADD    = 4'h1;
   localparam logic [3:0]  OP_SUB    = 4'h2;
   localparam logic [3:0]  OP_LOAD   = 4'h3;
   localparam logic [31:0] NOP_INSTR = 32'h0;

   localparam int unsigned OPC_HI = 31;
   localparam int unsigned OPC_LO = 28;
   localparam int unsigned RD_HI  = 27;
   localparam int unsigned RD_LO  = 24;
   localparam int unsigned RS1_HI = 23;
   localparam int unsigned RS1_LO = 20;
   localparam int unsigned RS2_HI = 19;
   localparam int unsigned RS2_LO = 16;

   typedef logic [3:0] reg_idx_t;

   typedef struct packed {
      logic     valid;
      reg_idx_t rd;
   } hist_t;

   function automatic logic reads_rs1(input logic [3:0] opcode);
      return (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_LOAD);
   endfunction

   function automatic logic reads_rs2(input logic [3:0] opcode);
      return (opcode == OP_ADD) || (opcode == OP_SUB);
   endfunction

endpackage

// File: rtl/instr_issue_unit_if.sv
// Upstream load handshake plus the instruction stream towards the processor.
interface instr_issue_if;

   logic [31:0] in_instr;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic [31:0] instruction;
   logic        out_bubble;

   modport master (
      output in_instr, in_valid, flush,
      input  in_ready, instruction, out_bubble
   );

   modport slave (
      input  in_instr, in_valid, flush,
      output in_ready, instruction, out_bubble
   );

endinterface

// File: rtl/issue_fifo.sv
// Synchronous FIFO with push, pop, flush, occupancy count and full/empty flags.
module issue_fifo #(
   parameter  int unsigned DEPTH = 4,
   parameter  int unsigned WIDTH = 32,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty
);

   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);

endmodule

// File: rtl/instr_issue_unit.sv
// Buffers upstream instructions and issues one per cycle, inserting NOP bubbles
// while the head reads a register still in flight in the processor pipeline.
module instr_issue_unit
   import issue_pkg::*;
#(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned HAZARD_DIST = 3,
   parameter int unsigned CNT_W       = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   instr_issue_if.slave           bus,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic [CNT_W-1:0]       issued_cnt,
   output logic [CNT_W-1:0]       bubble_cnt
);

   logic        full;
   logic        empty;
   logic        push;
   logic        pop;
   logic        hazard;
   logic [31:0] head;
   logic [31:0] instr_q;
   logic        bubble_q;
   hist_t       hist [HAZARD_DIST];

   assign bus.in_ready    = !full && !bus.flush && reset;
   assign push            = bus.in_valid && bus.in_ready;
   assign bus.instruction = instr_q;
   assign bus.out_bubble  = bubble_q;

   issue_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .push    (push),
      .pop     (pop),
      .flush   (bus.flush),
      .wr_data (bus.in_instr),
      .rd_data (head),
      .count   (fifo_count),
      .full    (full),
      .empty   (empty)
   );

   // History entries are only valid for rd != 0, so r0 reads never match.
   always_comb begin
      hazard = 1'b0;
      for (int unsigned i = 0; i < HAZARD_DIST; i++) begin
         if (hist[i].valid && reads_rs1(head[OPC_HI:OPC_LO]) &&
             (head[RS1_HI:RS1_LO] == hist[i].rd))
            hazard = 1'b1;
         if (hist[i].valid && reads_rs2(head[OPC_HI:OPC_LO]) &&
             (head[RS2_HI:RS2_LO] == hist[i].rd))
            hazard = 1'b1;
      end
   end

   assign pop = !empty && !hazard && !bus.flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr_q    <= NOP_INSTR;
         bubble_q   <= 1'b1;
         issued_cnt <= '0;
         bubble_cnt <= '0;
         for (int unsigned i = 0; i < HAZARD_DIST; i++) hist[i] <= '0;
      end else begin
         if (pop) begin
            instr_q  <= head;
            bubble_q <= 1'b0;
            if (issued_cnt != '1) issued_cnt <= issued_cnt + 1'b1;
         end else begin
            instr_q  <= NOP_INSTR;
            bubble_q <= 1'b1;
            if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
         end
         hist[0].valid <= pop && (head[RD_HI:RD_LO] != '0);
         hist[0].rd    <= pop ? head[RD_HI:RD_LO] : '0;
         for (int unsigned i = 1; i < HAZARD_DIST; i++) hist[i] <= hist[i-1];
      end
   end

endmodule
